// File: rtl/nts_rx_framer_pkg.sv
// Shared types and constants for the NTS RX framer: FSM states, counter width,
// byte-mask constants and the busy decode.
package nts_rx_framer_pkg;

  localparam int CNT_W = 32;
  localparam logic [7:0] MASK_NONE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_DISCARD,
    ST_CLEAR,
    ST_PROCESS
  } state_t;

  function automatic logic state_busy(input state_t s);
    return (s != ST_IDLE) && (s != ST_RECEIVE);
  endfunction

endpackage

// File: rtl/nts_rx_framer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module nts_rx_framer_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_areset)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nts_rx_framer.sv
// Captures one MAC RX frame into a word buffer, then replays it to the NTS
// parser as a clear pulse plus a burst of addressed words; counts drops.
module nts_rx_framer
  import nts_rx_framer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_start,
  input  logic                  i_rx_stop,
  input  logic                  i_rx_bad,
  output logic                  o_clear,
  output logic                  o_process,
  output logic [63:0]           o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [7:0]            o_last_word_data_valid,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_cnt_good,
  output logic [CNT_W-1:0]      o_cnt_bad,
  output logic [CNT_W-1:0]      o_cnt_overflow,
  output logic [CNT_W-1:0]      o_cnt_busy
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state;
  logic [LEN_W-1:0]      r_wr_idx, r_len, r_rd_cnt;
  logic [7:0]            r_mask, r_last;
  logic                  r_clear, r_process;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt_good, r_cnt_bad, r_cnt_overflow, r_cnt_busy;

  logic                  w_valid, w_capturing, w_replaying;
  logic                  w_start_acc, w_drop, w_data_acc, w_overflow;
  logic                  w_good, w_bad, w_busy_start, w_last_issue;
  logic [LEN_W-1:0]      w_next_idx;
  logic                  w_we, w_rd_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;

  assign w_valid      = |i_rx_data_valid;
  assign w_capturing  = (r_state == ST_IDLE) || (r_state == ST_RECEIVE);
  assign w_replaying  = (r_state == ST_CLEAR) || (r_state == ST_PROCESS);
  assign w_next_idx   = r_wr_idx + LEN_W'(1);

  // A start while capturing always restarts at address 0; in RECEIVE it drops the old frame.
  assign w_start_acc  = w_valid && i_rx_start && w_capturing;
  assign w_drop       = w_start_acc && (r_state == ST_RECEIVE);
  assign w_overflow   = w_valid && !i_rx_start && (r_state == ST_RECEIVE) && (w_next_idx == DEPTH);
  assign w_data_acc   = w_valid && !i_rx_start && (r_state == ST_RECEIVE) && !w_overflow;
  assign w_good       = (w_start_acc || w_data_acc) && i_rx_stop && !i_rx_bad;
  assign w_bad        = (w_start_acc || w_data_acc) && i_rx_stop && i_rx_bad;
  assign w_busy_start = w_valid && i_rx_start && w_replaying;

  assign w_last_issue = ((r_state == ST_CLEAR) && (r_len == LEN_W'(1))) ||
                        ((r_state == ST_PROCESS) && (r_rd_cnt == r_len - LEN_W'(1)));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_we      = w_start_acc || w_data_acc;
    w_wr_addr = '0;
    if (w_data_acc) w_wr_addr = w_next_idx[ADDR_WIDTH-1:0];
  end

  assign w_rd_en   = (r_state == ST_CLEAR) || ((r_state == ST_PROCESS) && (r_rd_cnt != r_len));
  assign w_rd_addr = (r_state == ST_CLEAR) ? '0 : r_rd_cnt[ADDR_WIDTH-1:0];

  nts_rx_framer_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(64)) u_ram (
    .i_clk     (i_clk),
    .i_areset  (i_areset),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (i_rx_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (o_data)
  );

  // NOTE: all state here is sequential, so it uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_state        <= ST_IDLE;
      r_wr_idx       <= '0;
      r_len          <= '0;
      r_rd_cnt       <= '0;
      r_mask         <= MASK_NONE;
      r_last         <= MASK_NONE;
      r_clear        <= 1'b0;
      r_process      <= 1'b0;
      r_addr         <= '0;
      r_cnt_good     <= '0;
      r_cnt_bad      <= '0;
      r_cnt_overflow <= '0;
      r_cnt_busy     <= '0;
    end else begin
      r_clear        <= 1'b0;
      r_cnt_good     <= r_cnt_good + CNT_W'(w_last_issue);
      r_cnt_bad      <= r_cnt_bad + CNT_W'(w_drop) + CNT_W'(w_bad);
      r_cnt_overflow <= r_cnt_overflow + CNT_W'(w_overflow);
      r_cnt_busy     <= r_cnt_busy + CNT_W'(w_busy_start);
      if (w_start_acc)     r_wr_idx <= '0;
      else if (w_data_acc) r_wr_idx <= w_next_idx;

      case (r_state)
        ST_IDLE, ST_RECEIVE: begin
          if (w_good) begin
            r_state <= ST_CLEAR;
            r_clear <= 1'b1;
            r_len   <= w_start_acc ? LEN_W'(1) : w_next_idx + LEN_W'(1);
            r_mask  <= i_rx_data_valid;
          end else if (w_bad) begin
            r_state <= ST_IDLE;
          end else if (w_start_acc) begin
            r_state <= ST_RECEIVE;
          end else if (w_overflow) begin
            r_state <= i_rx_stop ? ST_IDLE : ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (w_valid && i_rx_stop) r_state <= ST_IDLE;
        end
        ST_CLEAR: begin
          r_state   <= ST_PROCESS;
          r_process <= 1'b1;
          r_addr    <= '0;
          r_rd_cnt  <= LEN_W'(1);
          r_last    <= w_last_issue ? r_mask : MASK_NONE;
        end
        ST_PROCESS: begin
          if (r_rd_cnt == r_len) begin
            r_state   <= ST_IDLE;
            r_process <= 1'b0;
            r_addr    <= '0;
            r_last    <= MASK_NONE;
          end else begin
            r_addr   <= r_rd_cnt[ADDR_WIDTH-1:0];
            r_rd_cnt <= r_rd_cnt + LEN_W'(1);
            r_last   <= w_last_issue ? r_mask : MASK_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_clear                = r_clear;
  assign o_process              = r_process;
  assign o_addr                 = r_addr;
  assign o_last_word_data_valid = r_last;
  assign o_busy                 = state_busy(r_state);
  assign o_cnt_good             = r_cnt_good;
  assign o_cnt_bad              = r_cnt_bad;
  assign o_cnt_overflow         = r_cnt_overflow;
  assign o_cnt_busy             = r_cnt_busy;

endmodule

// File: tb/tb_nts_rx_framer.sv
// Directed bench for nts_rx_framer with an 8-word buffer: replay timing,
// single-word, bad, overflow, busy-drop and mid-replay reset scenarios.
module tb_nts_rx_framer;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          i_areset = 1'b1;
  logic [7:0]    i_rx_data_valid = '0;
  logic [63:0]   i_rx_data = '0;
  logic          i_rx_start = 1'b0, i_rx_stop = 1'b0, i_rx_bad = 1'b0;
  logic          o_clear, o_process, o_busy;
  logic [63:0]   o_data;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_last;
  logic [31:0]   o_cnt_good, o_cnt_bad, o_cnt_overflow, o_cnt_busy;

  typedef struct {
    int          cyc;
    int          addr;
    logic [63:0] data;
    logic [7:0]  last;
  } rec_t;

  rec_t proc_q[$];
  int   clr_q[$];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  nts_rx_framer #(.ADDR_WIDTH(AW)) dut (
    .i_clk                  (clk),
    .i_areset               (i_areset),
    .i_rx_data_valid        (i_rx_data_valid),
    .i_rx_data              (i_rx_data),
    .i_rx_start             (i_rx_start),
    .i_rx_stop              (i_rx_stop),
    .i_rx_bad               (i_rx_bad),
    .o_clear                (o_clear),
    .o_process              (o_process),
    .o_data                 (o_data),
    .o_addr                 (o_addr),
    .o_last_word_data_valid (o_last),
    .o_busy                 (o_busy),
    .o_cnt_good             (o_cnt_good),
    .o_cnt_bad              (o_cnt_bad),
    .o_cnt_overflow         (o_cnt_overflow),
    .o_cnt_busy             (o_cnt_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every clear pulse and process word together with its cycle number.
  always @(negedge clk) begin
    if (o_clear) clr_q.push_back(cyc);
    if (o_process) proc_q.push_back('{cyc, int'(o_addr), o_data, o_last});
  end

  function automatic logic [63:0] word_of(input int f, input int k);
    return {8'(f), 8'(k), 48'h0123_4567_89ab};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic flush();
    clr_q.delete();
    proc_q.delete();
  endtask

  // Drive an n-word frame on consecutive cycles; s is the cycle its stop is presented.
  task automatic send_frame(input int f, input int n, input logic [7:0] m,
                            input logic bad, output int s);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_rx_data       = word_of(f, k);
      i_rx_data_valid = (k == n - 1) ? m : 8'hff;
      i_rx_start      = (k == 0);
      i_rx_stop       = (k == n - 1);
      i_rx_bad        = bad && (k == n - 1);
    end
    s = cyc;
    @(negedge clk);
    i_rx_data_valid = '0;
    i_rx_start      = 1'b0;
    i_rx_stop       = 1'b0;
    i_rx_bad        = 1'b0;
  endtask

  task automatic test_reset();
    i_areset = 1'b1;
    settle(2);
    n_total++;
    if ({o_clear, o_process, o_busy, o_addr, o_last, o_data} !== '0)
      $display("FAIL reset_outputs: got clr=%b proc=%b busy=%b addr=%0d last=%h data=%h, want all 0",
               o_clear, o_process, o_busy, o_addr, o_last, o_data);
    else n_pass++;
    n_total++;
    if ({o_cnt_good, o_cnt_bad, o_cnt_overflow, o_cnt_busy} !== '0)
      $display("FAIL reset_counters: got %0d %0d %0d %0d, want 0 0 0 0",
               o_cnt_good, o_cnt_bad, o_cnt_overflow, o_cnt_busy);
    else n_pass++;
    i_areset = 1'b0;
    settle(1);
  endtask

  task automatic test_good_frame();
    int s;
    flush();
    send_frame(1, 4, 8'hf0, 1'b0, s);
    settle(8);
    n_total++;
    if (clr_q.size() != 1 || clr_q[0] != s + 1)
      $display("FAIL good_clear: got %0d pulses first at %0d, want 1 at %0d", clr_q.size(), clr_q[0], s + 1);
    else n_pass++;
    n_total++;
    if (proc_q.size() != 4) $display("FAIL good_len: got %0d words, want 4", proc_q.size());
    else n_pass++;
    for (int k = 0; k < proc_q.size() && k < 4; k++) begin
      n_total++;
      if (proc_q[k].cyc != s + 2 + k || proc_q[k].addr != k || proc_q[k].data !== word_of(1, k) ||
          proc_q[k].last !== ((k == 3) ? 8'hf0 : 8'h00))
        $display("FAIL good_word%0d: got cyc=%0d addr=%0d data=%h last=%h, want cyc=%0d addr=%0d data=%h last=%h",
                 k, proc_q[k].cyc, proc_q[k].addr, proc_q[k].data, proc_q[k].last,
                 s + 2 + k, k, word_of(1, k), (k == 3) ? 8'hf0 : 8'h00);
      else n_pass++;
    end
    n_total++;
    if (o_cnt_good !== 32'd1) $display("FAIL good_cnt: got %0d, want 1", o_cnt_good);
    else n_pass++;
    n_total++;
    if (o_busy !== 1'b0 || o_process !== 1'b0 || o_last !== 8'h00)
      $display("FAIL good_idle: got busy=%b proc=%b last=%h, want 0 0 00", o_busy, o_process, o_last);
    else n_pass++;
  endtask

  task automatic test_single_word();
    int s;
    flush();
    send_frame(2, 1, 8'hff, 1'b0, s);
    settle(6);
    n_total++;
    if (clr_q.size() != 1 || clr_q[0] != s + 1)
      $display("FAIL single_clear: got %0d pulses first at %0d, want 1 at %0d", clr_q.size(), clr_q[0], s + 1);
    else n_pass++;
    n_total++;
    if (proc_q.size() != 1 || proc_q[0].cyc != s + 2 || proc_q[0].addr != 0 ||
        proc_q[0].data !== word_of(2, 0) || proc_q[0].last !== 8'hff)
      $display("FAIL single_word: got n=%0d cyc=%0d addr=%0d data=%h last=%h, want n=1 cyc=%0d addr=0 data=%h last=ff",
               proc_q.size(), proc_q[0].cyc, proc_q[0].addr, proc_q[0].data, proc_q[0].last, s + 2, word_of(2, 0));
    else n_pass++;
    n_total++;
    if (o_cnt_good !== 32'd2) $display("FAIL single_cnt: got %0d, want 2", o_cnt_good);
    else n_pass++;
  endtask

  task automatic test_bad_frame();
    int s;
    flush();
    send_frame(3, 3, 8'hff, 1'b1, s);
    settle(8);
    n_total++;
    if (clr_q.size() != 0 || proc_q.size() != 0)
      $display("FAIL bad_replay: got %0d clears %0d words, want 0 0", clr_q.size(), proc_q.size());
    else n_pass++;
    n_total++;
    if (o_cnt_bad !== 32'd1 || o_cnt_good !== 32'd2)
      $display("FAIL bad_cnt: got bad=%0d good=%0d, want 1 2", o_cnt_bad, o_cnt_good);
    else n_pass++;
    send_frame(4, 2, 8'h0f, 1'b0, s);
    settle(6);
    n_total++;
    if (proc_q.size() != 2) $display("FAIL after_bad_len: got %0d words, want 2", proc_q.size());
    else n_pass++;
    for (int k = 0; k < proc_q.size() && k < 2; k++) begin
      n_total++;
      if (proc_q[k].cyc != s + 2 + k || proc_q[k].addr != k || proc_q[k].data !== word_of(4, k) ||
          proc_q[k].last !== ((k == 1) ? 8'h0f : 8'h00))
        $display("FAIL after_bad_word%0d: got cyc=%0d addr=%0d data=%h last=%h, want cyc=%0d addr=%0d data=%h",
                 k, proc_q[k].cyc, proc_q[k].addr, proc_q[k].data, proc_q[k].last, s + 2 + k, k, word_of(4, k));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    int s;
    flush();
    send_frame(5, 9, 8'hff, 1'b0, s);
    settle(6);
    n_total++;
    if (clr_q.size() != 0 || proc_q.size() != 0)
      $display("FAIL ovf_replay: got %0d clears %0d words, want 0 0", clr_q.size(), proc_q.size());
    else n_pass++;
    n_total++;
    if (o_cnt_overflow !== 32'd1 || o_cnt_bad !== 32'd1)
      $display("FAIL ovf_cnt: got ovf=%0d bad=%0d, want 1 1", o_cnt_overflow, o_cnt_bad);
    else n_pass++;
    send_frame(6, 8, 8'h80, 1'b0, s);
    settle(12);
    n_total++;
    if (proc_q.size() != 8) $display("FAIL full_len: got %0d words, want 8", proc_q.size());
    else n_pass++;
    for (int k = 0; k < proc_q.size() && k < 8; k++) begin
      n_total++;
      if (proc_q[k].cyc != s + 2 + k || proc_q[k].addr != k || proc_q[k].data !== word_of(6, k) ||
          proc_q[k].last !== ((k == 7) ? 8'h80 : 8'h00))
        $display("FAIL full_word%0d: got cyc=%0d addr=%0d data=%h last=%h, want cyc=%0d addr=%0d data=%h",
                 k, proc_q[k].cyc, proc_q[k].addr, proc_q[k].data, proc_q[k].last, s + 2 + k, k, word_of(6, k));
      else n_pass++;
    end
    n_total++;
    if (o_cnt_good !== 32'd4) $display("FAIL full_cnt: got %0d, want 4", o_cnt_good);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s, s2;
    flush();
    send_frame(7, 4, 8'hff, 1'b0, s);
    send_frame(8, 3, 8'hff, 1'b0, s2);
    settle(10);
    n_total++;
    if (clr_q.size() != 1 || proc_q.size() != 4)
      $display("FAIL busy_replay: got %0d clears %0d words, want 1 4", clr_q.size(), proc_q.size());
    else n_pass++;
    for (int k = 0; k < proc_q.size() && k < 4; k++) begin
      n_total++;
      if (proc_q[k].cyc != s + 2 + k || proc_q[k].addr != k || proc_q[k].data !== word_of(7, k) ||
          proc_q[k].last !== ((k == 3) ? 8'hff : 8'h00))
        $display("FAIL busy_word%0d: got cyc=%0d addr=%0d data=%h last=%h, want cyc=%0d addr=%0d data=%h",
                 k, proc_q[k].cyc, proc_q[k].addr, proc_q[k].data, proc_q[k].last, s + 2 + k, k, word_of(7, k));
      else n_pass++;
    end
    n_total++;
    if (o_cnt_busy !== 32'd1 || o_cnt_good !== 32'd5 || o_cnt_bad !== 32'd1)
      $display("FAIL busy_cnt: got busy=%0d good=%0d bad=%0d, want 1 5 1", o_cnt_busy, o_cnt_good, o_cnt_bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_replay();
    int s;
    flush();
    send_frame(9, 6, 8'hff, 1'b0, s);
    settle(3);
    n_total++;
    if (o_process !== 1'b1 || o_addr !== 3'd2 || o_data !== word_of(9, 2))
      $display("FAIL mid_pre: got proc=%b addr=%0d data=%h, want 1 2 %h", o_process, o_addr, o_data, word_of(9, 2));
    else n_pass++;
    i_areset = 1'b1;
    settle(1);
    n_total++;
    if ({o_clear, o_process, o_busy, o_addr, o_last, o_data} !== '0 ||
        {o_cnt_good, o_cnt_bad, o_cnt_overflow, o_cnt_busy} !== '0)
      $display("FAIL mid_reset: got proc=%b busy=%b addr=%0d data=%h good=%0d, want all 0",
               o_process, o_busy, o_addr, o_data, o_cnt_good);
    else n_pass++;
    i_areset = 1'b0;
    flush();
    settle(6);
    n_total++;
    if (proc_q.size() != 0 || clr_q.size() != 0)
      $display("FAIL mid_resume: got %0d words %0d clears, want 0 0", proc_q.size(), clr_q.size());
    else n_pass++;
    send_frame(10, 3, 8'hc0, 1'b0, s);
    settle(6);
    n_total++;
    if (proc_q.size() != 3) $display("FAIL post_len: got %0d words, want 3", proc_q.size());
    else n_pass++;
    for (int k = 0; k < proc_q.size() && k < 3; k++) begin
      n_total++;
      if (proc_q[k].cyc != s + 2 + k || proc_q[k].addr != k || proc_q[k].data !== word_of(10, k) ||
          proc_q[k].last !== ((k == 2) ? 8'hc0 : 8'h00))
        $display("FAIL post_word%0d: got cyc=%0d addr=%0d data=%h last=%h, want cyc=%0d addr=%0d data=%h",
                 k, proc_q[k].cyc, proc_q[k].addr, proc_q[k].data, proc_q[k].last, s + 2 + k, k, word_of(10, k));
      else n_pass++;
    end
    n_total++;
    if (o_cnt_good !== 32'd1) $display("FAIL post_cnt: got %0d, want 1", o_cnt_good);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_single_word();
    test_bad_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid_replay();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
